// File: rtl/instruction_sequencer_if.sv
// Handshake and memory signals between the instruction sequencer, its program
// memory, the instruction decoder and the controlling host.
interface instruction_sequencer_if #(
  parameter int OPCODE_WIDTH  = 3,
  parameter int OPERAND_WIDTH = 8,
  parameter int ADDR_WIDTH    = 6
);
  logic                                  start;
  logic [ADDR_WIDTH:0]                   prog_len;
  logic                                  imem_en;
  logic [ADDR_WIDTH-1:0]                 imem_addr;
  logic [OPCODE_WIDTH+OPERAND_WIDTH-1:0] imem_rdata;
  logic [OPCODE_WIDTH-1:0]               opcode;
  logic [OPERAND_WIDTH-1:0]              operand;
  logic                                  instr_valid;
  logic                                  f_wait;
  logic                                  busy;
  logic                                  done;

  modport master (
    output start, prog_len, imem_rdata, f_wait,
    input  imem_en, imem_addr, opcode, operand, instr_valid, busy, done
  );

  modport slave (
    input  start, prog_len, imem_rdata, f_wait,
    output imem_en, imem_addr, opcode, operand, instr_valid, busy, done
  );
endinterface

// File: rtl/instruction_sequencer.sv
// Fetches words from a synchronous-read program memory and issues each opcode
// to the decoder for one cycle, stalling for WAIT operand cycles on f_wait.
module instruction_sequencer #(
  parameter int                      OPCODE_WIDTH  = 3,
  parameter int                      OPERAND_WIDTH = 8,
  parameter int                      ADDR_WIDTH    = 6,
  parameter logic [OPCODE_WIDTH-1:0] NOP_OPCODE    = 3'b111
) (
  input logic                     clk,
  input logic                     rst,
  instruction_sequencer_if.slave  bus
);
  localparam int IW = OPCODE_WIDTH + OPERAND_WIDTH;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_STALL = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]               state_q, state_d;
  logic [ADDR_WIDTH:0]      pc_q, pc_d;
  logic [ADDR_WIDTH:0]      len_q, len_d;
  logic [IW-1:0]            ir_q, ir_d;
  logic [OPERAND_WIDTH-1:0] cnt_q, cnt_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     imem_en_c;

  logic [OPCODE_WIDTH-1:0]  ir_opcode;
  logic [OPERAND_WIDTH-1:0] ir_operand;
  logic                     more_instr;

  assign ir_opcode  = ir_q[IW-1 -: OPCODE_WIDTH];
  assign ir_operand = ir_q[OPERAND_WIDTH-1:0];
  assign more_instr = (pc_q < len_q);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    len_d     = len_q;
    ir_d      = ir_q;
    cnt_d     = cnt_q;
    imem_en_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          len_d   = bus.prog_len;
          pc_d    = '0;
          state_d = (bus.prog_len != '0) ? S_FETCH : S_DONE;
        end
      end
      S_FETCH: begin
        imem_en_c = 1'b1;
        pc_d      = pc_q + (ADDR_WIDTH+1)'(1);
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        ir_d    = bus.imem_rdata;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (bus.f_wait && (ir_operand != '0)) begin
          cnt_d   = ir_operand;
          state_d = S_STALL;
        end else if (more_instr) begin
          // Overlapped fetch keeps the LOAD/ISSUE cadence at one instr per 2 cycles.
          imem_en_c = 1'b1;
          pc_d      = pc_q + (ADDR_WIDTH+1)'(1);
          state_d   = S_LOAD;
        end else begin
          state_d = S_DONE;
        end
      end
      S_STALL: begin
        cnt_d = cnt_q - OPERAND_WIDTH'(1);
        if (cnt_q == OPERAND_WIDTH'(1))
          state_d = more_instr ? S_FETCH : S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // The overlapped read enable depends on f_wait from the same ISSUE cycle,
  // so it is decoded from state rather than taken from a flop.
  assign bus.imem_en     = imem_en_c;
  assign bus.imem_addr   = pc_q[ADDR_WIDTH-1:0];
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.instr_valid = (state_q == S_ISSUE);
  assign bus.opcode      = (state_q == S_ISSUE) ? ir_opcode  : NOP_OPCODE;
  assign bus.operand     = (state_q == S_ISSUE) ? ir_operand : '0;
endmodule
